// File: rtl/expstate_irq_rx.sv
// Receive side of the TIE export-state link: change detector feeding a FWFT queue with a level IRQ.
// Optional saturating drop counter when EXPSTATE_IRQ_RX_OVFCNT_EN is defined.
module expstate_irq_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             BResetN,
  input  logic [WIDTH-1:0] TIE_EXPSTATE,
  output logic [WIDTH-1:0] TIE_IMPQ,
  output logic             TIE_IMPQ_Empty,
  input  logic             TIE_IMPQ_PopReq,
  output logic             BInterruptXX,
  input  logic             IrqEnable,
  output logic             Overflow,
  input  logic             OvfClr
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
  ,
  output logic [7:0]       OvfCount
`endif
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             changed;
  logic             pop;
  logic             push;
  logic             drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pop frees a slot on the same edge, so a full queue can still accept a push.
  always_comb begin
    changed    = (state == ST_RUN) && (TIE_EXPSTATE != ref_val);
    pop        = TIE_IMPQ_PopReq && (count != '0);
    push       = changed && ((count != FULL) || pop);
    drop       = changed && !push;
    count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      state        <= ST_INIT;
      ref_val      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      BInterruptXX <= 1'b0;
      Overflow     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
      OvfCount     <= 8'd0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          ref_val <= TIE_EXPSTATE;
          state   <= ST_RUN;
        end
        default: begin
          // Reference tracks the bus even on a drop, so a stuck value is not retried.
          if (changed) ref_val <= TIE_EXPSTATE;
        end
      endcase
      if (push) begin
        mem[wr_ptr] <= TIE_EXPSTATE;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      BInterruptXX <= IrqEnable && (count_next != '0);
      if (drop)        Overflow <= 1'b1;
      else if (OvfClr) Overflow <= 1'b0;
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
      if (drop)        OvfCount <= OvfClr ? 8'd1 : sat_inc8(OvfCount);
      else if (OvfClr) OvfCount <= 8'd0;
`endif
    end
  end

  // Head is shown even when empty; consumers qualify it with TIE_IMPQ_Empty.
  assign TIE_IMPQ       = mem[rd_ptr];
  assign TIE_IMPQ_Empty = (count == '0);

endmodule

// File: tb/tb_expstate_irq_rx.sv
// Bench for expstate_irq_rx: queue-based reference model compared every cycle, plus directed literal checks.
module tb_expstate_irq_rx;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] bus = 32'hDEADBEEF;
  logic             pop_req = 1'b0;
  logic             irq_en = 1'b1;
  logic             ovf_clr = 1'b0;
  logic [WIDTH-1:0] impq;
  logic             empty;
  logic             irq;
  logic             ovf;
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
  logic [7:0]       ovf_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  expstate_irq_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(clk),
    .BResetN(rst_n),
    .TIE_EXPSTATE(bus),
    .TIE_IMPQ(impq),
    .TIE_IMPQ_Empty(empty),
    .TIE_IMPQ_PopReq(pop_req),
    .BInterruptXX(irq),
    .IrqEnable(irq_en),
    .Overflow(ovf),
    .OvfClr(ovf_clr)
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
    ,
    .OvfCount(ovf_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted values plus the last seen bus value.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_ref;
  bit               m_first;
  bit               m_irq;
  bit               m_ovf;
  int               m_cnt;
  bit               m_pop;
  bit               m_chg;
  bit               m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ref   = '0;
      m_first = 1'b1;
      m_irq   = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
    end else begin
      m_pop  = pop_req && (m_q.size() != 0);
      m_chg  = !m_first && (bus != m_ref);
      m_drop = m_chg && (m_q.size() == DEPTH) && !m_pop;
      if (m_first || m_chg) m_ref = bus;
      m_first = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (m_chg && !m_drop) m_q.push_back(bus);
      m_ovf = m_drop || (m_ovf && !ovf_clr);
      if (m_drop) m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      else if (ovf_clr) m_cnt = 0;
      m_irq = irq_en && (m_q.size() != 0);
    end
  end

  always @(negedge clk) begin
    chk("model_empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
    chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    chk("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (m_q.size() != 0) chk("model_head", impq, m_q[0]);
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
    chk("model_ovfcnt", {24'd0, ovf_count}, m_cnt);
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pop_once();
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
  endtask

  logic [WIDTH-1:0] pool [8];
  int               pop_pct;

  initial begin
    #12;
    chk("rst_impq", impq, 32'h0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      chk("init_empty", {31'd0, empty}, 32'd1);
      chk("init_irq", {31'd0, irq}, 32'd0);
    end

    bus = 32'h00000001;
    tick();
    chk("chg_head", impq, 32'h00000001);
    chk("chg_empty", {31'd0, empty}, 32'd0);
    chk("chg_irq", {31'd0, irq}, 32'd1);
    tick();
    tick();
    pop_once();
    chk("pop_empty", {31'd0, empty}, 32'd1);
    chk("pop_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus = 32'hA0000001 + i;
      tick();
    end
    chk("six_ovf", {31'd0, ovf}, 32'd1);
`ifdef EXPSTATE_IRQ_RX_OVFCNT_EN
    chk("six_ovfcnt", {24'd0, ovf_count}, 32'd2);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("six_head", impq, 32'hA0000001 + i);
      chk("six_nonempty", {31'd0, empty}, 32'd0);
      pop_once();
    end
    chk("six_drained", {31'd0, empty}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", {31'd0, ovf}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      bus = 32'hB0000001 + i;
      tick();
    end
    bus = 32'hB0000005;
    pop_once();
    chk("fullpp_ovf", {31'd0, ovf}, 32'd0);
    chk("fullpp_head", impq, 32'hB0000002);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_order", impq, 32'hB0000002 + i);
      pop_once();
    end
    chk("fullpp_drained", {31'd0, empty}, 32'd1);

    irq_en = 1'b0;
    bus = 32'hC0000001;
    tick();
    bus = 32'hC0000002;
    tick();
    tick();
    chk("gate_irq_off", {31'd0, irq}, 32'd0);
    chk("gate_nonempty", {31'd0, empty}, 32'd0);
    irq_en = 1'b1;
    tick();
    chk("gate_irq_on", {31'd0, irq}, 32'd1);
    pop_once();
    pop_once();
    chk("gate_drained", {31'd0, empty}, 32'd1);
    pop_once();
    chk("empty_pop_empty", {31'd0, empty}, 32'd1);
    chk("empty_pop_irq", {31'd0, irq}, 32'd0);
    chk("empty_pop_ovf", {31'd0, ovf}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      bus = 32'hD0000001 + i;
      tick();
    end
    chk("pre_rst_head", impq, 32'hD0000001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_impq", impq, 32'h0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int phase = 0; phase < 6; phase++) begin
      pop_pct = (phase % 3 == 0) ? 15 : ((phase % 3 == 1) ? 50 : 90);
      repeat (500) begin
        if ($urandom_range(0, 99) < 60) bus = pool[$urandom_range(0, 7)];
        pop_req = ($urandom_range(0, 99) < pop_pct);
        irq_en  = ($urandom_range(0, 7) != 0);
        ovf_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    pop_req = 1'b0;
    ovf_clr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/expstate_irq_rx.md
# expstate_irq_rx

Receiving end of the TIE export-state link between two cores. It samples the 32-bit export-state bus driven by the producer core and detects each change of value. Each changed value goes into a small first-word-fall-through queue that the consumer core drains through a TIE input-queue interface. A level interrupt is raised toward the consumer core while any value is pending.

## Interface
Parameters:
- WIDTH, 32, export-state bus width.
- DEPTH, 4, queue entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  in  1  single clock for the whole block.
- BResetN  in  1  reset, asynchronous assert, active-low.
- TIE_EXPSTATE  in  WIDTH  export state from the producer core, synchronous to CLK.
- TIE_IMPQ  out  WIDTH  queue head data (first-word fall-through).
- TIE_IMPQ_Empty  out  1  queue empty.
- TIE_IMPQ_PopReq  in  1  consumer pop request.
- BInterruptXX  out  1  level interrupt to the consumer core.
- IrqEnable  in  1  interrupt gate; when 0, BInterruptXX is forced low and the queue still fills.
- Overflow  out  1  sticky; a value was dropped.
- OvfClr  in  1  clears Overflow.

## Operation
- Reset values: TIE_IMPQ = 0, TIE_IMPQ_Empty = 1, BInterruptXX = 0, Overflow = 0. Queue pointers and count = 0. State = INIT. Reference register = 0.
- State machine:
  - INIT: on the first clock edge after reset release, load TIE_EXPSTATE into the reference register without a push, then go to RUN.
  - RUN: every edge, compare TIE_EXPSTATE with the reference register. If they differ, push TIE_EXPSTATE and update the reference. If they are equal, do nothing.
  - RUN never exits except by reset.
- Push:
  - Written at the wr_ptr entry; wr_ptr increments modulo DEPTH.
  - The count is PTR_W+1 bits wide, from 0 to DEPTH.
- Pop:
  - Happens when TIE_IMPQ_PopReq=1 and count≠0; rd_ptr increments modulo DEPTH.
  - A pop on an empty queue is ignored. It has no side effects.
- Full and push without pop: the new value is dropped and Overflow sets. The reference register is still updated, so an unchanged bus does not retry the push.
- Full with simultaneous push and pop: both take effect, count stays at DEPTH, and there is no overflow.
- Empty with simultaneous push and pop: the pop is ignored, the push is accepted, and count becomes 1.
- TIE_IMPQ always shows mem[rd_ptr], even when empty (stale data). Consumers must qualify it with TIE_IMPQ_Empty.
- BInterruptXX is registered. Its next value is IrqEnable & (count_next ≠ 0).
- Overflow:
  - OvfClr=1 clears it at the next edge.
  - If OvfClr=1 and a new overflow happen on the same edge, Overflow ends at 1 (set wins).
- Reset mid-operation: asynchronous flush of all state. Queued values are lost. The first post-reset sample becomes the new reference and is not pushed.

## Timing
- Change latency:
  - A new value sampled at edge N appears on TIE_IMPQ and drops TIE_IMPQ_Empty after edge N (one cycle).
  - BInterruptXX rises after the same edge N.
- Pop latency: PopReq sampled at edge N; the new head or Empty=1 is visible after edge N. BInterruptXX falls after edge N if the queue became empty.
- Change throughput: one change per cycle is sustained while the consumer keeps up.
- IrqEnable 0→1 with a non-empty queue: BInterruptXX rises after the next edge.
- All outputs come from flops or registered memory/pointers. There are no combinational paths from inputs to outputs.

## Configuration
- EXPSTATE_IRQ_RX_OVFCNT_EN defined:
  - Adds output OvfCount [7:0], reset value 0.
  - It increments on each dropped push and saturates at 255.
  - OvfClr zeroes it together with Overflow.
  - If OvfClr and a drop happen on the same edge, OvfCount ends at 1.
- Not defined: OvfCount port and logic are absent; only the sticky Overflow flag exists.

## Test plan
- Reset release with TIE_EXPSTATE=0xDEADBEEF, held for 10 cycles: no push, and TIE_IMPQ_Empty stays 1 and BInterruptXX stays 0 throughout.
- Bus changes 0xDEADBEEF→0x00000001 at edge N, no pop:
  - After edge N: TIE_IMPQ=0x00000001, Empty=0, BInterruptXX=1.
  - Pop at edge N+3: Empty=1 and BInterruptXX=0 after edge N+3.
- Six distinct values on consecutive cycles with DEPTH=4 and no pop:
  - The first four are queued and Overflow=1.
  - Popping 4× returns those values in order, then Empty=1.
  - With OVFCNT_EN defined, OvfCount=2.
- Queue full, and on the same edge a change plus PopReq=1: count stays 4, Overflow stays 0, and the head advances to the second value.
- IrqEnable=0 with 2 entries queued: BInterruptXX=0. IrqEnable→1: BInterruptXX=1 one edge later. PopReq while empty: no change.
- Assert BResetN low with 3 entries queued: all outputs return to reset values asynchronously. After release, the current bus value is not pushed.
